// File: rtl/ppu_pkg.sv
// Shared PPU definitions: lane index type and lane count.
// Imported by every PPU module that handles per-lane streams.
// Contents: lane_t (1-bit lane index), PPU_NUM_LANES.
package ppu_pkg;

   localparam int PPU_NUM_LANES = 2;

   typedef logic lane_t;

endpackage : ppu_pkg

// File: rtl/ppu_sync_fifo.sv
// Single-clock FIFO, DEPTH entries of N bits, first-word fall-through on dout.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty.
module ppu_sync_fifo #(
   parameter int N     = 10,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [N-1:0] din,
   input  logic         pop,
   output logic [N-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit separates full from empty when the index bits match.
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic [N-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: entries are only read between a push and its pop.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule : ppu_sync_fifo

// File: rtl/ppu_lane_merge.sv
// Merges two lane result streams into one lane-tagged stream via round-robin.
// Latency: 2 cycles from input accept to out_valid when the output stage is free.
// Backpressure: per-lane FIFO plus output register; inK_ready = !fullK (registered).
// Ports: clk, rst_n, in0/in1 data/valid/ready, out_data/out_lane/out_valid/out_ready.
module ppu_lane_merge
   import ppu_pkg::*;
#(
   parameter int N     = 10,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in0_data,
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [N-1:0] in1_data,
   input  logic         in1_valid,
   output logic         in1_ready,
   output logic [N-1:0] out_data,
   output lane_t        out_lane,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [PPU_NUM_LANES-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [N-1:0]             fifo_din  [PPU_NUM_LANES];
   logic [N-1:0]             fifo_dout [PPU_NUM_LANES];

   logic [N-1:0] out_data_q, out_data_d;
   lane_t        out_lane_q, out_lane_d;
   logic         out_valid_q, out_valid_d;
   lane_t        prio_q, prio_d;
   lane_t        gnt;
   logic         load;

   assign fifo_din[0]  = in0_data;
   assign fifo_din[1]  = in1_data;
   assign fifo_push[0] = in0_valid && !fifo_full[0];
   assign fifo_push[1] = in1_valid && !fifo_full[1];

   // Ready depends only on FIFO pointer state, never on same-cycle pops.
   assign in0_ready = !fifo_full[0];
   assign in1_ready = !fifo_full[1];

   for (genvar k = 0; k < PPU_NUM_LANES; k++) begin : g_lane
      ppu_sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (fifo_push[k]),
         .din   (fifo_din[k]),
         .pop   (fifo_pop[k]),
         .dout  (fifo_dout[k]),
         .full  (fifo_full[k]),
         .empty (fifo_empty[k])
      );
   end

   always_comb begin
      // A lone non-empty lane wins outright; prio only breaks ties.
      gnt = prio_q;
      if (!fifo_empty[0] && fifo_empty[1]) gnt = 1'b0;
      if (fifo_empty[0] && !fifo_empty[1]) gnt = 1'b1;

      load     = (!out_valid_q || out_ready) && (fifo_empty != 2'b11);
      fifo_pop = '0;
      if (load) fifo_pop[gnt] = 1'b1;

      out_data_d  = out_data_q;
      out_lane_d  = out_lane_q;
      out_valid_d = out_valid_q;
      prio_d      = prio_q;
      if (load) begin
         out_data_d  = fifo_dout[gnt];
         out_lane_d  = gnt;
         out_valid_d = 1'b1;
         prio_d      = !gnt;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_lane_q  <= 1'b0;
         out_valid_q <= 1'b0;
         prio_q      <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_valid_q <= out_valid_d;
         prio_q      <= prio_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_valid = out_valid_q;

endmodule : ppu_lane_merge

// File: tb/tb_ppu_lane_merge.sv
// Scoreboard bench for ppu_lane_merge: per-lane expected queues filled at accept,
// popped by a negedge monitor on every output transfer; directed test sequence.
module tb_ppu_lane_merge;

   localparam int N     = 10;
   localparam int DEPTH = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] in0_data = '0;
   logic         in0_valid = 1'b0;
   logic         in0_ready;
   logic [N-1:0] in1_data = '0;
   logic         in1_valid = 1'b0;
   logic         in1_ready;
   logic [N-1:0] out_data;
   logic         out_lane;
   logic         out_valid;
   logic         out_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [N-1:0] exp0[$];
   logic [N-1:0] exp1[$];
   logic [N:0]   obs_q[$];

   bit wrap_mode = 1'b0;
   int acc0, out0;

   ppu_lane_merge #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Lane-0 traffic counters used to predict in0_ready from occupancy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc0 <= 0;
         out0 <= 0;
      end else begin
         if (in0_valid && in0_ready) acc0 <= acc0 + 1;
         if (out_valid && out_ready && !out_lane) out0 <= out0 + 1;
      end
   end

   // Monitor: every output transfer must match the head of its lane's queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         obs_q.push_back({out_lane, out_data});
         if (!out_lane) begin
            chk("lane0_output_expected", exp0.size() > 0, 1);
            if (exp0.size() > 0) chk("lane0_data", out_data, exp0.pop_front());
         end else begin
            chk("lane1_output_expected", exp1.size() > 0, 1);
            if (exp1.size() > 0) chk("lane1_data", out_data, exp1.pop_front());
         end
      end
      if (rst_n && wrap_mode)
         chk("in0_ready_vs_occupancy", in0_ready,
             ((acc0 - out0) - int'(out_valid)) < DEPTH);
   end

   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic send(input int lane, input logic [N-1:0] d);
      bit ok = 1'b0;
      if (lane == 0) begin in0_data = d; in0_valid = 1'b1; end
      else           begin in1_data = d; in1_valid = 1'b1; end
      for (int t = 0; t < 100 && !ok; t++) begin
         ok = (lane == 0) ? in0_ready : in1_ready;
         @(posedge clk); #1;
      end
      if (lane == 0) in0_valid = 1'b0; else in1_valid = 1'b0;
      if (ok) begin
         if (lane == 0) exp0.push_back(d); else exp1.push_back(d);
      end else begin
         chk("send_accepted", ok, 1);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_lane", out_lane, 0);
      chk("rst_in0_ready", in0_ready, 1);
      chk("rst_in1_ready", in1_ready, 1);
      exp0.delete(); exp1.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 300 && (exp0.size() + exp1.size()) != 0; t++) @(posedge clk);
      #1;
      chk("drained", exp0.size() + exp1.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      bit send_done;
      logic [N:0] fair_exp [6];
      fair_exp = '{{1'b0, 10'd1}, {1'b1, 10'd10}, {1'b0, 10'd2},
                   {1'b1, 10'd20}, {1'b0, 10'd3}, {1'b1, 10'd30}};

      // Power-on reset
      @(posedge clk); #1;
      apply_reset();

      // Reset mid-stream: 5 in the output register, 6 in the lane-0 FIFO
      out_ready = 1'b0;
      send(0, 10'd5);
      send(0, 10'd6);
      @(posedge clk); #1;
      chk("pre_rst_out_data", out_data, 5);
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_stale", out_valid, 0);
      end

      // Single-lane latency
      in0_data = 10'd123; in0_valid = 1'b1;
      @(posedge clk); #1;
      in0_valid = 1'b0;
      exp0.push_back(10'd123);
      chk("lat_cycle1_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_cycle2_valid", out_valid, 1);
      chk("lat_cycle2_data", out_data, 123);
      chk("lat_cycle2_lane", out_lane, 0);
      @(posedge clk); #1;
      chk("lat_cycle3_valid", out_valid, 0);

      // Round-robin fairness from prio=0
      apply_reset();
      out_ready = 1'b1;
      obs_q.delete();
      fork
         begin send(0, 10'd1); send(0, 10'd2); send(0, 10'd3); end
         begin send(1, 10'd10); send(1, 10'd20); send(1, 10'd30); end
      join
      wait_drain();
      chk("fair_count", obs_q.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < obs_q.size()) chk("fair_order", obs_q[i], fair_exp[i]);

      // Backpressure / full on lane 1
      out_ready = 1'b0;
      send(1, 10'd7);
      send(1, 10'd8);
      send(1, 10'd9);
      chk("bp_in1_ready_low", in1_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 7);
      chk("bp_out_lane", out_lane, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_data", out_data, 7);
      end
      out_ready = 1'b1;
      wait_drain();

      // Wrap boundary: 64 values on lane 0 with out_ready toggling
      apply_reset();
      wrap_mode = 1'b1;
      send_done = 1'b0;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 64; i++) send(0, 10'(64 + i));
            send_done = 1'b1;
         end
         begin
            while (!send_done) begin
               @(posedge clk); #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();
      wrap_mode = 1'b0;
      chk("wrap_total_out", out0, 64);

      // Hold stability with both lanes pushing behind a stalled output
      out_ready = 1'b0;
      send(0, 10'd100);
      @(posedge clk); #1;
      fork
         begin send(0, 10'd101); send(0, 10'd102); end
         begin send(1, 10'd200); send(1, 10'd201); end
      join_none
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 100);
         chk("hold_lane", out_lane, 0);
      end
      wait fork;
      out_ready = 1'b1;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_ppu_lane_merge

// File: doc/ppu_lane_merge.md
# ppu_lane_merge

Merges the two result streams from the lanes fed by the 1-to-2 operand demux back into a single output stream. Each lane has a small buffering FIFO; a round-robin arbiter pops one lane per cycle into a registered output stage with valid/ready handshake. It sits directly downstream of the two execution lanes, at the PPU result port, and tags each result with its source lane.

## Interface
Parameters:
- `N`, 10, result word width in bits.
- `DEPTH`, 2, entries per lane FIFO; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_data`  in  N  lane 0 result.
- `in0_valid`  in  1  lane 0 result valid.
- `in0_ready`  out  1  lane 0 FIFO can accept.
- `in1_data`  in  N  lane 1 result.
- `in1_valid`  in  1  lane 1 result valid.
- `in1_ready`  out  1  lane 1 FIFO can accept.
- `out_data`  out  N  merged result.
- `out_lane`  out  1  source lane of `out_data` (0/1).
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  consumer accepts.

## Operation
- Transfer on any port occurs when valid && ready are both high at a rising edge.
- `inK_ready` = !fullK and is driven from registered state only; there is no combinational path from `out_ready` or `inK_valid`. A push into a full FIFO cannot occur, even when a pop happens in the same cycle.
- Output stage is one register {data, lane, valid}. It loads when (!out_valid || out_ready) and at least one FIFO is non-empty. This gives full throughput: one result per cycle.
- Arbiter: a 1-bit priority pointer `prio`, with reset value 0.
  - If only one FIFO is non-empty, that lane is granted.
  - If both are non-empty, lane `prio` is granted.
  - After every grant, `prio` ← !granted_lane.
- Per-lane order is preserved. There is no ordering guarantee across lanes.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full and empty are decided by the MSB compare, and pointers wrap modulo 2·DEPTH.
- A simultaneous push and pop on the same non-full, non-empty FIFO leaves the occupancy unchanged.
- `out_data` and `out_lane` are held stable while out_valid && !out_ready.
- Reset (asserting at any time, including mid-transfer):
  - all FIFOs are emptied;
  - out_valid=0, out_data=0, out_lane=0, prio=0;
  - in0_ready=in1_ready=1 after the first edge following deassertion (they read 1 throughout reset since the FIFOs are empty).
  - In-flight results are discarded; upstream must not rely on them.

## Timing
- Latency: a result accepted on lane K at edge t appears with out_valid=1 after edge t+1 (visible in cycle t+2), provided the output stage is free.
- Throughput: 1 result/cycle total. With both lanes saturated, each lane gets 1 result per 2 cycles in strict alternation.
- Backpressure: with out_ready=0, each lane stores DEPTH results plus 1 in the output register. inK_ready falls in the cycle after the DEPTH-th push.
- Ready recovery: inK_ready rises in the cycle after the edge at which lane K is popped.

## Structure
- Shared package `ppu_pkg`: add `lane_t` (1-bit lane index typedef) and the constant `PPU_NUM_LANES = 2`.
- Sub-module `ppu_sync_fifo #(N, DEPTH)`, instantiated once per lane.
  - Ports: clk, rst_n, push, din, pop, dout, full, empty.
  - Async active-low reset.
- Arbiter and output register live in the top module, with no further hierarchy.

## Test plan
- Reset mid-stream: fill lane 0 with 5, 6 and hold out_ready=0, then pulse rst_n low. Require out_valid=0, out_data=0 and both readies=1 immediately; no stale 5 or 6 appears afterwards.
- Single-lane latency: with out_ready=1, push in0_data=123 at edge t. Require out_valid=1, out_data=123, out_lane=0 in cycle t+2, then out_valid=0 in cycle t+3.
- Round-robin fairness: lane 0 pushes 1, 2, 3 and lane 1 pushes 10, 20, 30, all back-to-back, with out_ready=1. Required output sequence is 1, 10, 2, 20, 3, 30 with lanes 0, 1, 0, 1, 0, 1.
- Backpressure/full: with out_ready=0 and DEPTH=2, push 7, 8, 9 on lane 1. Required: 7 sits in the output register, in1_ready=0 after 8 and 9 are stored, and 7 is held stable. Then raise out_ready and require 7, 8, 9 in order with no loss or duplication.
- Simultaneous push/pop at the wrap boundary: stream 64 sequential values on lane 0 with out_ready toggling 1,0,1,0,... Require every value exactly once and in order, in0_ready never high while the FIFO is full, and no push accepted while full.
- Hold stability: with out_valid=1 and out_ready=0 for 10 cycles while both lanes push, out_data and out_lane must remain unchanged throughout.
